// File: rtl/wb_arbiter_2_masters_pkg.sv
// ============================================================================
// Module   : wb_arbiter_2_masters_pkg
// Brief    : Shared Wishbone widths and arbiter owner-state encodings.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_arbiter_2_masters_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_SEL_WIDTH  = 4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GRANT_M0 = 2'd1;
    localparam logic [1:0] ST_GRANT_M1 = 2'd2;

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_2_masters.sv
// ============================================================================
// Module   : wb_arbiter_2_masters
// Brief    : Two-master Wishbone classic arbiter onto one shared slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter_2_masters
    import wb_arbiter_2_masters_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_m0_we,
    input  logic                    i_m0_stb,
    input  logic                    i_m0_cyc,
    input  logic [WB_SEL_WIDTH-1:0] i_m0_sel,
    input  logic [DATA_WIDTH-1:0]   i_m0_dat,
    input  logic [ADDR_WIDTH-1:0]   i_m0_adr,
    output logic [DATA_WIDTH-1:0]   o_m0_dat,
    output logic                    o_m0_ack,
    output logic                    o_m0_int,

    input  logic                    i_m1_we,
    input  logic                    i_m1_stb,
    input  logic                    i_m1_cyc,
    input  logic [WB_SEL_WIDTH-1:0] i_m1_sel,
    input  logic [DATA_WIDTH-1:0]   i_m1_dat,
    input  logic [ADDR_WIDTH-1:0]   i_m1_adr,
    output logic [DATA_WIDTH-1:0]   o_m1_dat,
    output logic                    o_m1_ack,
    output logic                    o_m1_int,

    output logic                    o_s_we,
    output logic                    o_s_stb,
    output logic                    o_s_cyc,
    output logic [WB_SEL_WIDTH-1:0] o_s_sel,
    output logic [DATA_WIDTH-1:0]   o_s_dat,
    output logic [ADDR_WIDTH-1:0]   o_s_adr,
    input  logic [DATA_WIDTH-1:0]   i_s_dat,
    input  logic                    i_s_ack,
    input  logic                    i_s_int
);

    logic [1:0] r_state;
    logic [1:0] w_next_state;

    // Releasing master hands over to a waiting peer before it can be re-granted.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (i_m0_cyc)      w_next_state = ST_GRANT_M0;
                else if (i_m1_cyc) w_next_state = ST_GRANT_M1;
                else               w_next_state = ST_IDLE;
            end
            ST_GRANT_M0: begin
                if (i_m0_cyc)      w_next_state = ST_GRANT_M0;
                else if (i_m1_cyc) w_next_state = ST_GRANT_M1;
                else               w_next_state = ST_IDLE;
            end
            ST_GRANT_M1: begin
                if (i_m1_cyc)      w_next_state = ST_GRANT_M1;
                else if (i_m0_cyc) w_next_state = ST_GRANT_M0;
                else               w_next_state = ST_IDLE;
            end
            default:               w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        o_s_we   = 1'b0;
        o_s_stb  = 1'b0;
        o_s_cyc  = 1'b0;
        o_s_sel  = '0;
        o_s_dat  = '0;
        o_s_adr  = '0;
        o_m0_ack = 1'b0;
        o_m0_dat = '0;
        o_m1_ack = 1'b0;
        o_m1_dat = '0;
        case (r_state)
            ST_GRANT_M0: begin
                o_s_we   = i_m0_we;
                o_s_stb  = i_m0_stb;
                o_s_cyc  = i_m0_cyc;
                o_s_sel  = i_m0_sel;
                o_s_dat  = i_m0_dat;
                o_s_adr  = i_m0_adr;
                o_m0_ack = i_s_ack;
                o_m0_dat = i_s_dat;
            end
            ST_GRANT_M1: begin
                o_s_we   = i_m1_we;
                o_s_stb  = i_m1_stb;
                o_s_cyc  = i_m1_cyc;
                o_s_sel  = i_m1_sel;
                o_s_dat  = i_m1_dat;
                o_s_adr  = i_m1_adr;
                o_m1_ack = i_s_ack;
                o_m1_dat = i_s_dat;
            end
            default: ;
        endcase
    end

    assign o_m0_int = i_s_int;
    assign o_m1_int = i_s_int;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_2_masters.sv
// ============================================================================
// Module   : tb_wb_arbiter_2_masters
// Brief    : Arbiter bench with a 1024-word Wishbone block-RAM slave model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter_2_masters;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        m0_we = 0, m0_stb = 0, m0_cyc = 0;
    logic [3:0]  m0_sel = 0;
    logic [31:0] m0_wdat = 0, m0_adr = 0;
    logic [31:0] m0_rdat;
    logic        m0_ack, m0_int;

    logic        m1_we = 0, m1_stb = 0, m1_cyc = 0;
    logic [3:0]  m1_sel = 0;
    logic [31:0] m1_wdat = 0, m1_adr = 0;
    logic [31:0] m1_rdat;
    logic        m1_ack, m1_int;

    logic        s_we, s_stb, s_cyc;
    logic [3:0]  s_sel;
    logic [31:0] s_wdat, s_adr;
    logic [31:0] s_rdat;
    logic        s_ack;
    logic        s_int = 1'b0;

    logic [31:0] bram [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_q [$];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    wb_arbiter_2_masters #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_m0_we(m0_we), .i_m0_stb(m0_stb), .i_m0_cyc(m0_cyc), .i_m0_sel(m0_sel),
        .i_m0_dat(m0_wdat), .i_m0_adr(m0_adr), .o_m0_dat(m0_rdat),
        .o_m0_ack(m0_ack), .o_m0_int(m0_int),
        .i_m1_we(m1_we), .i_m1_stb(m1_stb), .i_m1_cyc(m1_cyc), .i_m1_sel(m1_sel),
        .i_m1_dat(m1_wdat), .i_m1_adr(m1_adr), .o_m1_dat(m1_rdat),
        .o_m1_ack(m1_ack), .o_m1_int(m1_int),
        .o_s_we(s_we), .o_s_stb(s_stb), .o_s_cyc(s_cyc), .o_s_sel(s_sel),
        .o_s_dat(s_wdat), .o_s_adr(s_adr),
        .i_s_dat(s_rdat), .i_s_ack(s_ack), .i_s_int(s_int)
    );

    // Block-RAM slave: word addressed, registered read data and one-beat ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ack  <= 1'b0;
            s_rdat <= '0;
        end else if (s_cyc && s_stb && !s_ack) begin
            s_ack  <= 1'b1;
            s_rdat <= bram[s_adr[9:0]];
            if (s_we) begin
                for (int b = 0; b < 4; b++)
                    if (s_sel[b]) bram[s_adr[9:0]][8*b +: 8] <= s_wdat[8*b +: 8];
            end
        end else begin
            s_ack <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat);
        if (m == 0) begin
            m0_cyc = 1; m0_stb = 1; m0_we = we; m0_adr = adr; m0_wdat = dat; m0_sel = 4'hF;
        end else begin
            m1_cyc = 1; m1_stb = 1; m1_we = we; m1_adr = adr; m1_wdat = dat; m1_sel = 4'hF;
        end
    endtask

    // One Wishbone classic beat; the peer master must never see an ack meanwhile.
    task automatic beat(input int m, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic drop_cyc);
        logic        got;
        logic        ack;
        logic        oth;
        logic [31:0] rd;
        drive(m, we, adr, dat);
        if (we) ref_mem[adr[9:0]] = dat;
        else    exp_q.push_back(ref_mem[adr[9:0]]);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            ack = (m == 0) ? m0_ack : m1_ack;
            oth = (m == 0) ? m1_ack : m0_ack;
            rd  = (m == 0) ? m0_rdat : m1_rdat;
            check($sformatf("peer_ack_m%0d", 1 - m), {31'd0, oth}, 32'd0);
            if (ack) begin
                got = 1;
                if (!we) check($sformatf("rdata_m%0d_%h", m, adr), rd, exp_q.pop_front());
            end
        end
        check($sformatf("ack_seen_m%0d_%h", m, adr), {31'd0, got}, 32'd1);
        if (m == 0) begin m0_stb = 0; m0_we = 0; if (drop_cyc) m0_cyc = 0; end
        else        begin m1_stb = 0; m1_we = 0; if (drop_cyc) m1_cyc = 0; end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bram[i]    = '0;
            ref_mem[i] = '0;
        end

        // Reset holds the slave side quiet even with a request pending.
        m0_cyc = 1; m0_stb = 1;
        #12;
        check("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
        check("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        check("idle_s_cyc", {31'd0, s_cyc}, 32'd0);
        check("idle_s_stb", {31'd0, s_stb}, 32'd0);
        check("idle_s_adr", s_adr, 32'd0);
        check("idle_s_dat", s_wdat, 32'd0);
        check("idle_s_sel", {28'd0, s_sel}, 32'd0);
        s_int = 1; #1;
        check("int_m0", {31'd0, m0_int}, 32'd1);
        check("int_m1", {31'd0, m1_int}, 32'd1);
        s_int = 0; #1;
        check("int_m0_low", {31'd0, m0_int}, 32'd0);

        // Single-master write then read.
        beat(0, 1, 32'h10, 32'hDEADBEEF, 1);
        beat(0, 0, 32'h10, 32'h0, 1);
        check("ref_deadbeef", ref_mem[10'h10], 32'hDEADBEEF);

        // Simultaneous request from idle: m0 first, then m1 one edge after release.
        drive(1, 1, 32'h31, 32'h00001234);
        beat(0, 1, 32'h30, 32'hA5A5A5A5, 1);
        @(posedge clk); #1;
        check("handover_s_adr", s_adr, 32'h31);
        check("handover_s_cyc", {31'd0, s_cyc}, 32'd1);
        beat(1, 1, 32'h31, 32'h00001234, 1);
        beat(1, 0, 32'h30, 32'h0, 0);
        beat(1, 0, 32'h31, 32'h0, 1);

        // Grant latency from idle is exactly one edge.
        @(posedge clk); #1;
        drive(1, 1, 32'h20, 32'd1);
        #1;
        check("lat_before_edge", {31'd0, s_cyc}, 32'd0);
        @(posedge clk); #1;
        check("lat_after_edge", {31'd0, s_cyc}, 32'd1);
        drive(0, 0, 32'h20, 32'h0);
        // m1 burst of five writes with cyc held while m0 waits.
        for (int k = 0; k < 5; k++)
            beat(1, 1, 32'h20 + k, 32'd1 + k, (k == 4));
        @(posedge clk); #1;
        check("m0_granted_adr", s_adr, 32'h20);
        check("m0_granted_we", {31'd0, s_we}, 32'd0);
        for (int k = 0; k < 5; k++)
            beat(0, 0, 32'h20 + k, 32'h0, (k == 4));

        // stb low with cyc held keeps ownership.
        @(posedge clk); #1;
        drive(0, 0, 32'h21, 32'h0);
        @(posedge clk); #1;
        m0_stb = 0;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h24;
        repeat (3) @(posedge clk);
        #1;
        check("hold_s_adr", s_adr, 32'h21);
        check("hold_m1_ack", {31'd0, m1_ack}, 32'd0);
        m0_cyc = 0; m1_cyc = 0; m1_stb = 0;
        @(posedge clk); #1;
        check("release_idle", {31'd0, s_cyc}, 32'd0);

        // Asynchronous reset mid-read.
        drive(0, 0, 32'h10, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_ack", {31'd0, m0_ack}, 32'd1);
        check("pre_rst_dat", m0_rdat, 32'hDEADBEEF);
        #1 rst = 1;
        #1;
        check("arst_s_cyc", {31'd0, s_cyc}, 32'd0);
        check("arst_s_stb", {31'd0, s_stb}, 32'd0);
        check("arst_m0_ack", {31'd0, m0_ack}, 32'd0);
        check("arst_m0_dat", m0_rdat, 32'd0);
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk); rst = 0;
        beat(1, 1, 32'h40, 32'hCAFEF00D, 1);
        beat(1, 0, 32'h40, 32'h0, 1);
        beat(1, 0, 32'h22, 32'h0, 1);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
